// File: rtl/huffman_stream_arbiter.sv
// huffman_stream_arbiter
// Shares one huffman_encode instance among NUM_CH code-source FIFOs.
// A grant covers a whole message: it starts at the first code pop and ends
// once the EOS code has been consumed and the encoder output has gone quiet.
// Each packed output word is tagged with the owning channel on out_chan.
// Optional feature macro: HUFF_ARB_PRIO0_EN (channel 0 gets strict priority).
module huffman_stream_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int C_WIDTH      = 4,
    parameter int EOS_CODE     = 8,
    parameter int QUIET_CYCLES = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         src_rdy,
    input  logic [NUM_CH*C_WIDTH-1:0] src_code,
    output logic [NUM_CH-1:0]         src_pop,
    output logic [C_WIDTH-1:0]        enc_code,
    output logic                      enc_rdy,
    input  logic                      enc_pop,
    input  logic                      enc_push,
    input  logic                      out_not_full,
    output logic [CH_W-1:0]           out_chan,
    output logic                      busy,
    output logic                      msg_done
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

    state_t          r_state;
    logic [CH_W-1:0] r_owner;
    logic [CH_W-1:0] r_rr_ptr;
    logic            r_pop_d;
    logic            r_msg_done;
    logic [QW-1:0]   r_quiet_cnt;

    logic [CH_W:0]   w_pick;     // {found, channel}
    logic            w_quiet_inc;
    logic            w_eos_seen;

    // First requester strictly after ptr, wrapping modulo NUM_CH.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   ptr);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        idx = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!res[CH_W] && req[idx])
                res = {1'b1, CH_W'(idx)};
        end
        return res;
    endfunction

    // Arbitration winner for the next IDLE decision.
    always_comb begin
        w_pick = rr_pick(src_rdy, r_rr_ptr);
`ifdef HUFF_ARB_PRIO0_EN
        if (src_rdy[0])
            w_pick = {1'b1, CH_W'(0)};
`endif
    end

    // The owner's code stays on the encoder for the whole grant, including the
    // cycle after a pop when the encoder actually samples it.
    assign enc_code    = src_code[int'(r_owner)*C_WIDTH +: C_WIDTH];
    assign w_eos_seen  = r_pop_d && (enc_code == C_WIDTH'(EOS_CODE));
    assign w_quiet_inc = !enc_push && out_not_full;

    // Route the owner's handshake to the encoder only while granted.
    always_comb begin
        enc_rdy = 1'b0;
        src_pop = '0;
        if (r_state == S_GRANT) begin
            enc_rdy          = src_rdy[r_owner];
            src_pop[r_owner] = enc_pop;
        end
    end

    assign out_chan = r_owner;
    assign busy     = (r_state != S_IDLE);
    assign msg_done = r_msg_done;

    // Grant FSM: pick in IDLE, watch for EOS in GRANT, wait out the flush in DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= CH_W'(NUM_CH - 1);
            r_pop_d     <= 1'b0;
            r_msg_done  <= 1'b0;
            r_quiet_cnt <= '0;
        end else begin
            r_msg_done <= 1'b0;
            r_pop_d    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick[CH_W]) begin
                        r_owner <= w_pick[CH_W-1:0];
`ifdef HUFF_ARB_PRIO0_EN
                        // Channel 0 grants do not disturb the rotation of the others.
                        if (w_pick[CH_W-1:0] != '0)
                            r_rr_ptr <= w_pick[CH_W-1:0];
`else
                        r_rr_ptr <= w_pick[CH_W-1:0];
`endif
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_pop_d <= enc_pop;
                    if (w_eos_seen) begin
                        r_state     <= S_DRAIN;
                        r_quiet_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (enc_push) begin
                        r_quiet_cnt <= '0;
                    end else if (w_quiet_inc) begin
                        if (r_quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                            r_quiet_cnt <= '0;
                            r_msg_done  <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_quiet_cnt <= r_quiet_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A pop outside GRANT means the encoder is out of step with the arbiter.
    pop_outside_grant: assert property (@(posedge clk) disable iff (reset)
        enc_pop |-> (r_state == S_GRANT))
        else $error("enc_pop while not granted");

endmodule

// File: tb/tb_huffman_stream_arbiter.sv
// Directed bench for huffman_stream_arbiter (default parameters).
module tb_huffman_stream_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_rdy;
    logic [15:0] src_code;
    logic [3:0]  src_pop;
    logic [3:0]  enc_code;
    logic        enc_rdy;
    logic        enc_pop;
    logic        enc_push;
    logic        out_not_full;
    logic [1:0]  out_chan;
    logic        busy;
    logic        msg_done;

    int n_cmp = 0;
    int n_mis = 0;

    huffman_stream_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .src_rdy      (src_rdy),
        .src_code     (src_code),
        .src_pop      (src_pop),
        .enc_code     (enc_code),
        .enc_rdy      (enc_rdy),
        .enc_pop      (enc_pop),
        .enc_push     (enc_push),
        .out_not_full (out_not_full),
        .out_chan     (out_chan),
        .busy         (busy),
        .msg_done     (msg_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called right after the grant edge: one EOS pop, then a clean drain.
    task automatic do_msg(input int ch);
        chk("grant_chan", 32'(out_chan), ch);
        chk("grant_busy", 32'(busy), 1);
        chk("grant_rdy", 32'(enc_rdy), 1);
        enc_pop = 1'b1;
        #1;
        chk("grant_pop", 32'(src_pop), 1 << ch);
        tick;
        enc_pop = 1'b0;
        tick;
        chk("drain_busy", 32'(busy), 1);
        chk("drain_rdy", 32'(enc_rdy), 0);
        repeat (9) tick;
        chk("drain_no_done", 32'(msg_done), 0);
        tick;
        chk("rel_done", 32'(msg_done), 1);
        chk("rel_busy", 32'(busy), 0);
    endtask

    initial begin
        reset        = 1'b1;
        src_rdy      = 4'b0000;
        src_code     = 16'h8888;
        enc_pop      = 1'b0;
        enc_push     = 1'b0;
        out_not_full = 1'b1;
        tick;
        tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(msg_done), 0);
        chk("rst_chan", 32'(out_chan), 0);
        chk("rst_pop", 32'(src_pop), 0);
        chk("rst_rdy", 32'(enc_rdy), 0);
        reset = 1'b0;

        // Single channel 2, codes 0,4,8; other channels carry EOS that must be ignored
        src_code = 16'h8088;
        src_rdy  = 4'b0100;
        #1;
        chk("t1_idle_rdy", 32'(enc_rdy), 0);
        tick;
        chk("t1_grant_chan", 32'(out_chan), 2);
        chk("t1_grant_rdy", 32'(enc_rdy), 1);
        enc_pop = 1'b1;
        #1;
        chk("t1_pop_mirror", 32'(src_pop), 4'b0100);
        tick;
        src_code[11:8] = 4'h0;
        #1;
        chk("t1_code0", 32'(enc_code), 0);
        tick;
        src_code[11:8] = 4'h4;
        #1;
        chk("t1_code4", 32'(enc_code), 4);
        chk("t1_busy_mid", 32'(busy), 1);
        tick;
        src_code[11:8] = 4'h8;
        enc_pop = 1'b0;
        src_rdy = 4'b0000;
        #1;
        chk("t1_pop_off", 32'(src_pop), 0);
        tick;
        src_rdy = 4'b0100;
        #1;
        chk("t1_drain_rdy", 32'(enc_rdy), 0);
        src_rdy  = 4'b0000;
        enc_push = 1'b1;
        #1;
        chk("t1_push_chan", 32'(out_chan), 2);
        tick;
        enc_push = 1'b0;
        repeat (9) tick;
        chk("t1_busy_pre", 32'(busy), 1);
        chk("t1_done_pre", 32'(msg_done), 0);
        tick;
        chk("t1_done", 32'(msg_done), 1);
        chk("t1_busy_end", 32'(busy), 0);
        tick;
        chk("t1_done_once", 32'(msg_done), 0);
        chk("t1_stay_idle", 32'(busy), 0);

        reset = 1'b1;
        tick;
        reset    = 1'b0;
        src_code = 16'h8888;

`ifdef HUFF_ARB_PRIO0_EN
        // Channel 0 has strict priority over channel 2
        src_rdy = 4'b0101;
        tick;
        do_msg(0);
        tick;
        do_msg(0);
        src_rdy = 4'b0100;
        tick;
        do_msg(2);
        src_rdy = 4'b0101;
        tick;
        do_msg(0);
`else
        // All four request at once: round-robin 0,1,2,3,0
        src_rdy = 4'b1111;
        tick;
        do_msg(0);
        tick;
        do_msg(1);
        tick;
        do_msg(2);
        tick;
        do_msg(3);
        tick;
        do_msg(0);

        // Channel 1 stalls mid-message; nobody else is served
        src_rdy  = 4'b0010;
        src_code = 16'h8838;
        tick;
        chk("t3_chan", 32'(out_chan), 1);
        chk("t3_done_low", 32'(msg_done), 0);
        enc_pop = 1'b1;
        tick;
        enc_pop = 1'b0;
        src_rdy = 4'b1101;
        #1;
        chk("t3_rdy_drop", 32'(enc_rdy), 0);
        repeat (20) tick;
        chk("t3_hold_busy", 32'(busy), 1);
        chk("t3_hold_chan", 32'(out_chan), 1);
        chk("t3_hold_rdy", 32'(enc_rdy), 0);
        src_rdy  = 4'b1111;
        src_code = 16'h8888;
        #1;
        chk("t3_resume_rdy", 32'(enc_rdy), 1);
        enc_pop = 1'b1;
        #1;
        chk("t3_resume_pop", 32'(src_pop), 4'b0010);
        tick;
        enc_pop = 1'b0;
        tick;
        chk("t3_drain", 32'(busy), 1);
        repeat (10) tick;
        chk("t3_done", 32'(msg_done), 1);

        // Backpressure in DRAIN freezes the quiet count
        tick;
        chk("t4_chan", 32'(out_chan), 2);
        enc_pop = 1'b1;
        tick;
        enc_pop = 1'b0;
        tick;
        chk("t4_drain_rdy", 32'(enc_rdy), 0);
        chk("t4_drain_pop", 32'(src_pop), 0);
        enc_push = 1'b1;
        #1;
        chk("t4_push_chan", 32'(out_chan), 2);
        tick;
        enc_push = 1'b0;
        repeat (3) tick;
        out_not_full = 1'b0;
        repeat (50) tick;
        chk("t4_hold_busy", 32'(busy), 1);
        chk("t4_hold_done", 32'(msg_done), 0);
        out_not_full = 1'b1;
        repeat (6) tick;
        chk("t4_pre_busy", 32'(busy), 1);
        tick;
        chk("t4_done", 32'(msg_done), 1);
        chk("t4_idle", 32'(busy), 0);

        // Reset while channel 3 holds the grant
        tick;
        chk("t5_chan", 32'(out_chan), 3);
        enc_pop = 1'b1;
        #1;
        chk("t5_pop", 32'(src_pop), 4'b1000);
        reset   = 1'b1;
        enc_pop = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_chan", 32'(out_chan), 0);
        chk("t5_rst_pop", 32'(src_pop), 0);
        chk("t5_rst_rdy", 32'(enc_rdy), 0);
        tick;
        reset = 1'b0;
        tick;
        chk("t5_regrant_chan", 32'(out_chan), 0);
        chk("t5_regrant_busy", 32'(busy), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
